// File: rtl/gmux_cfg_pkg.sv
// gmux_cfg_pkg: shared defaults, CRC polynomial and loader FSM states
package gmux_cfg_pkg;
    localparam int         GMUX_BITS_DEF = 46;
    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic [7:0] CRC_POLY      = 8'h07;
    typedef enum logic [1:0] {IDLE, DATA, CRC, COMMIT} cfg_state_t;
endpackage

// File: rtl/cfg_crc8.sv
// cfg_crc8: one byte step of CRC-8, MSB-first, no reflection
module cfg_crc8 import gmux_cfg_pkg::*; (
    input  logic [7:0] crc_in,
    input  logic [7:0] data_in,
    output logic [7:0] crc_out
);
    // fold the byte into the remainder, then shift out eight bits
    always_comb begin
        crc_out = crc_in ^ data_in;
        for (int i = 0; i < 8; i++)
            crc_out = crc_out[7] ? ({crc_out[6:0], 1'b0} ^ CRC_POLY) : {crc_out[6:0], 1'b0};
    end
endmodule

// File: rtl/gmux_cfg_loader.sv
// gmux_cfg_loader: framed, CRC-checked loader for the global mux configuration
module gmux_cfg_loader import gmux_cfg_pkg::*; #(
    parameter int         GMUX_BITS  = GMUX_BITS_DEF,
    parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF,
    parameter int         DATA_BYTES = (GMUX_BITS + 7) / 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           cfg_data,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic                 cfg_abort,
    output logic [0:GMUX_BITS-1] global_mux,
    output logic                 cfg_loaded,
    output logic                 cfg_done,
    output logic                 cfg_error,
    output logic [7:0]           err_count
);
    localparam int             SW       = DATA_BYTES * 8;
    localparam int             CW       = DATA_BYTES > 1 ? $clog2(DATA_BYTES) : 1;
    localparam logic [CW-1:0]  LAST     = CW'(DATA_BYTES - 1);
    localparam logic [SW-1:0]  PAD_MASK = {SW{1'b1}} << GMUX_BITS;

    cfg_state_t    state;
    logic [SW-1:0] shadow;
    logic [7:0]    crc;
    logic [7:0]    crc_next;
    logic [CW-1:0] cnt;
    logic          xfer;
    logic          pad_ok;

    assign xfer   = cfg_valid & cfg_ready;
    assign pad_ok = (shadow & PAD_MASK) == '0;

    cfg_crc8 u_crc (
        .crc_in  (crc),
        .data_in (cfg_data),
        .crc_out (crc_next)
    );

    // frame FSM: sync hunt, payload capture, CRC check, one-cycle commit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shadow     <= '0;
            crc        <= '0;
            cnt        <= '0;
            global_mux <= '0;
            cfg_ready  <= 1'b1;
            cfg_loaded <= 1'b0;
            cfg_done   <= 1'b0;
            cfg_error  <= 1'b0;
            err_count  <= '0;
        end else begin
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
            if (cfg_abort && state != COMMIT) begin
                state     <= IDLE;
                shadow    <= '0;
                crc       <= '0;
                cnt       <= '0;
                cfg_ready <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (xfer && cfg_data == SYNC_BYTE) begin
                        shadow <= '0;
                        crc    <= '0;
                        cnt    <= '0;
                        state  <= DATA;
                    end
                    DATA: if (xfer) begin
                        shadow[{cnt, 3'b000} +: 8] <= cfg_data;
                        crc   <= crc_next;
                        cnt   <= cnt + 1'b1;
                        state <= cnt == LAST ? CRC : DATA;
                    end
                    CRC: if (xfer) begin
                        if (cfg_data == crc && pad_ok) begin
                            state     <= COMMIT;
                            cfg_ready <= 1'b0;
                        end else begin
                            state     <= IDLE;
                            cfg_error <= 1'b1;
                            err_count <= err_count + {7'd0, err_count != 8'hFF};
                        end
                    end
                    COMMIT: begin
                        for (int i = 0; i < GMUX_BITS; i++)
                            global_mux[i] <= shadow[i];
                        cfg_loaded <= 1'b1;
                        cfg_done   <= 1'b1;
                        cfg_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_gmux_cfg_loader.sv
// tb_gmux_cfg_loader: table-driven frames plus hand sequences for abort, reset and saturation
module tb_gmux_cfg_loader;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  cfg_data;
    logic        cfg_valid;
    logic        cfg_ready;
    logic        cfg_abort;
    logic [0:45] global_mux;
    logic        cfg_loaded;
    logic        cfg_done;
    logic        cfg_error;
    logic [7:0]  err_count;

    int n_pass = 0;
    int n_total = 0;
    logic [45:0] exp_gm = '0;
    int exp_err = 0;

    always #5 clk = ~clk;

    gmux_cfg_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_data   (cfg_data),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_abort  (cfg_abort),
        .global_mux (global_mux),
        .cfg_loaded (cfg_loaded),
        .cfg_done   (cfg_done),
        .cfg_error  (cfg_error),
        .err_count  (err_count)
    );

    typedef struct {
        logic [47:0] pay;
        logic        crc_bad;
        logic        commit;
    } vec_t;

    function automatic logic [7:0] crc8(input logic [47:0] p);
        logic [7:0] c = 8'h00;
        for (int k = 0; k < 6; k++) begin
            c ^= p[8*k +: 8];
            for (int b = 0; b < 8; b++)
                c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

    function automatic logic [63:0] gm();
        logic [63:0] p = '0;
        for (int i = 0; i < 46; i++) p[i] = global_mux[i];
        return p;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic send(input logic [7:0] b);
        int t = 0;
        @(negedge clk);
        cfg_data  = b;
        cfg_valid = 1'b1;
        while (!cfg_ready && t < 10) begin
            @(negedge clk);
            t++;
        end
        if (!cfg_ready) chk("ready_timeout", 64'(cfg_ready), 64'd1);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic run_frame(input logic [47:0] p, input logic [7:0] c);
        send(8'hA5);
        for (int k = 0; k < 6; k++) send(p[8*k +: 8]);
        send(c);
    endtask

    vec_t v[5];

    initial begin
        rst_n = 1'b0;
        cfg_data = '0;
        cfg_valid = 1'b0;
        cfg_abort = 1'b0;
        v[0] = '{48'h0000_0000_0000, 1'b0, 1'b1};
        v[1] = '{48'h3FFF_FFFF_FFFF, 1'b0, 1'b1};
        v[2] = '{48'h0000_0000_0000, 1'b1, 1'b0};
        v[3] = '{48'h4000_0000_0000, 1'b0, 1'b0};
        v[4] = '{48'h2B9A_7856_34A5, 1'b0, 1'b1};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 64'(cfg_ready), 64'd1);
        chk("rst_gm", gm(), 64'd0);
        chk("rst_flags", {61'd0, cfg_loaded, cfg_done, cfg_error}, 64'd0);
        chk("rst_errcnt", 64'(err_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_frame(v[i].pay, v[i].crc_bad ? crc8(v[i].pay) ^ 8'h01 : crc8(v[i].pay));
            if (v[i].commit) exp_gm = v[i].pay[45:0];
            else exp_err++;
            chk($sformatf("v%0d_ready_n", i), 64'(cfg_ready), 64'(!v[i].commit));
            chk($sformatf("v%0d_err_pulse", i), 64'(cfg_error), 64'(!v[i].commit));
            chk($sformatf("v%0d_errcnt", i), 64'(err_count), 64'(exp_err));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_gm", i), gm(), 64'(exp_gm));
            chk($sformatf("v%0d_done", i), 64'(cfg_done), 64'(v[i].commit));
            chk($sformatf("v%0d_ready_n1", i), 64'(cfg_ready), 64'd1);
            chk($sformatf("v%0d_err_n1", i), 64'(cfg_error), 64'd0);
            chk($sformatf("v%0d_loaded", i), 64'(cfg_loaded), 64'd1);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_once", i), 64'(cfg_done), 64'd0);
        end

        send(8'h12);
        send(8'h34);
        chk("garbage_err", {62'd0, cfg_error, cfg_done}, 64'd0);
        send(8'hA5);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        @(negedge clk);
        cfg_abort = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 8'hA5;
        @(posedge clk);
        #1;
        cfg_abort = 1'b0;
        cfg_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("abort_quiet", {62'd0, cfg_error, cfg_done}, 64'd0);
        chk("abort_gm", gm(), 64'(exp_gm));
        chk("abort_errcnt", 64'(err_count), 64'(exp_err));
        run_frame(48'h0605_0403_0201, crc8(48'h0605_0403_0201));
        exp_gm = 46'h0605_0403_0201;
        @(posedge clk);
        #1;
        chk("after_abort_done", 64'(cfg_done), 64'd1);
        chk("after_abort_gm", gm(), 64'(exp_gm));

        run_frame(48'h0011_2233_4455, crc8(48'h0011_2233_4455));
        cfg_abort = 1'b1;
        @(posedge clk);
        #1;
        cfg_abort = 1'b0;
        exp_gm = 46'h0011_2233_4455;
        chk("abort_in_commit_done", 64'(cfg_done), 64'd1);
        chk("abort_in_commit_gm", gm(), 64'(exp_gm));

        run_frame(48'h1111_1111_1111, crc8(48'h1111_1111_1111));
        run_frame(48'h0A0B_0C0D_0E0F, crc8(48'h0A0B_0C0D_0E0F));
        @(posedge clk);
        #1;
        exp_gm = 46'h0A0B_0C0D_0E0F;
        chk("b2b_done", 64'(cfg_done), 64'd1);
        chk("b2b_gm", gm(), 64'(exp_gm));

        for (int i = 0; i < 256; i++) run_frame(48'h0, 8'h01);
        @(posedge clk);
        #1;
        chk("err_saturate", 64'(err_count), 64'd255);
        chk("sat_gm", gm(), 64'(exp_gm));

        send(8'hA5);
        send(8'h77);
        send(8'h88);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_gm", gm(), 64'd0);
        chk("midrst_flags", {61'd0, cfg_loaded, cfg_done, cfg_error}, 64'd0);
        chk("midrst_errcnt", 64'(err_count), 64'd0);
        chk("midrst_ready", 64'(cfg_ready), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("midrst_no_err%0d", i), {63'd0, cfg_error}, 64'd0);
        end
        chk("midrst_errcnt_after", 64'(err_count), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
